// File: rtl/rob_commit_buffer.sv
// Reorder-buffer storage: dispatch allocates at the tail, the CDB completes entries by tag, and the head retires in order.
// Optional macro ROB_COMMIT_BYPASS_EN lets a CDB completion to the head entry retire in the same cycle.
module rob_commit_buffer #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned TAG_BITS = 1,
  parameter int unsigned DW       = 32,
  parameter int unsigned AW       = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [1:0]          alloc_inst_type,
  input  logic [5:0]          alloc_reg_dest,
  input  logic [AW-1:0]       alloc_mem_dest,
  input  logic                alloc_jump_reg,
  output logic [TAG_BITS-1:0] alloc_tag,
  input  logic                cdb_valid,
  input  logic [TAG_BITS-1:0] cdb_tag,
  input  logic [DW-1:0]       cdb_value,
  input  logic [AW-1:0]       cdb_mem_dest,
  input  logic [TAG_BITS-1:0] rd_tag,
  output logic                rd_ready,
  output logic [DW-1:0]       rd_value,
  output logic                commit_valid,
  input  logic                commit_ready,
  output logic [TAG_BITS-1:0] commit_tag,
  output logic [1:0]          commit_inst_type,
  output logic [5:0]          commit_reg_dest,
  output logic [AW-1:0]       commit_mem_dest,
  output logic [DW-1:0]       commit_value,
  output logic                commit_jump_reg,
  output logic [TAG_BITS:0]   count
);

  localparam int unsigned CW         = TAG_BITS + 1;
  localparam logic [1:0]  TYPE_STORE = 2'd1;
  localparam logic [1:0]  TYPE_NOP   = 2'd3;

  typedef struct packed {
    logic [1:0]    inst_type;
    logic [5:0]    reg_dest;
    logic [AW-1:0] mem_dest;
    logic [DW-1:0] value;
    logic          jump_reg;
    logic          ready;
  } rob_entry_t;

  rob_entry_t          entry_q [DEPTH];
  rob_entry_t          entry_d [DEPTH];
  logic [DEPTH-1:0]    occ_q, occ_d;
  logic [TAG_BITS-1:0] head_q, head_d;
  logic [TAG_BITS-1:0] tail_q, tail_d;
  logic [CW-1:0]       count_q, count_d;

  rob_entry_t head_e;
  logic       alloc_fire;
  logic       cpl_fire;
  logic       commit_fire;
  logic       bypass_hit;

  // Handshakes: a completion only lands on an occupied, not-yet-ready entry.
  assign head_e      = entry_q[head_q];
  assign alloc_ready = (count_q < CW'(DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign cpl_fire    = cdb_valid && occ_q[cdb_tag] && !entry_q[cdb_tag].ready;
`ifdef ROB_COMMIT_BYPASS_EN
  assign bypass_hit  = cpl_fire && (cdb_tag == head_q);
`else
  assign bypass_hit  = 1'b0;
`endif
  assign commit_valid = occ_q[head_q] && (head_e.ready || bypass_hit);
  assign commit_fire  = commit_valid && commit_ready;

  assign alloc_tag        = tail_q;
  assign count            = count_q;
  assign commit_tag       = head_q;
  assign commit_inst_type = head_e.inst_type;
  assign commit_reg_dest  = head_e.reg_dest;
  assign commit_jump_reg  = head_e.jump_reg;
  assign commit_value     = bypass_hit ? cdb_value : head_e.value;
  assign commit_mem_dest  = (bypass_hit && (head_e.inst_type == TYPE_STORE)) ? cdb_mem_dest
                                                                             : head_e.mem_dest;
  assign rd_ready = occ_q[rd_tag] && entry_q[rd_tag].ready;
  assign rd_value = entry_q[rd_tag].value;

  // Next-state: flush wins over allocate, complete and commit.
  always_comb begin
    entry_d = entry_q;
    occ_d   = occ_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      occ_d = '0;
      for (int i = 0; i < int'(DEPTH); i++) entry_d[i].ready = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (cpl_fire) begin
        entry_d[cdb_tag].value = cdb_value;
        entry_d[cdb_tag].ready = 1'b1;
        if (entry_q[cdb_tag].inst_type == TYPE_STORE) entry_d[cdb_tag].mem_dest = cdb_mem_dest;
      end
      if (commit_fire) begin
        occ_d[head_q] = 1'b0;
        head_d        = TAG_BITS'(head_q + 1'b1);
      end
      if (alloc_fire) begin
        entry_d[tail_q].inst_type = alloc_inst_type;
        entry_d[tail_q].reg_dest  = alloc_reg_dest;
        entry_d[tail_q].mem_dest  = alloc_mem_dest;
        entry_d[tail_q].value     = '0;
        entry_d[tail_q].jump_reg  = alloc_jump_reg;
        entry_d[tail_q].ready     = (alloc_inst_type == TYPE_NOP);
        occ_d[tail_q]             = 1'b1;
        tail_d                    = TAG_BITS'(tail_q + 1'b1);
      end
      case ({alloc_fire, commit_fire})
        2'b10:   count_d = CW'(count_q + 1'b1);
        2'b01:   count_d = CW'(count_q - 1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= '0;
      occ_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) entry_q[i] <= entry_d[i];
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  count_bounded_a: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_rob_commit_buffer.sv
// Randomized bench for rob_commit_buffer against a program-order queue model; honours ROB_COMMIT_BYPASS_EN.
module tb_rob_commit_buffer;

  localparam int unsigned DEPTH    = 2;
  localparam int unsigned TAG_BITS = 1;
  localparam int unsigned DW       = 32;
  localparam int unsigned AW       = 26;

  logic                clk = 1'b0;
  logic                rst;
  logic                flush;
  logic                alloc_valid;
  logic                alloc_ready;
  logic [1:0]          alloc_inst_type;
  logic [5:0]          alloc_reg_dest;
  logic [AW-1:0]       alloc_mem_dest;
  logic                alloc_jump_reg;
  logic [TAG_BITS-1:0] alloc_tag;
  logic                cdb_valid;
  logic [TAG_BITS-1:0] cdb_tag;
  logic [DW-1:0]       cdb_value;
  logic [AW-1:0]       cdb_mem_dest;
  logic [TAG_BITS-1:0] rd_tag;
  logic                rd_ready;
  logic [DW-1:0]       rd_value;
  logic                commit_valid;
  logic                commit_ready;
  logic [TAG_BITS-1:0] commit_tag;
  logic [1:0]          commit_inst_type;
  logic [5:0]          commit_reg_dest;
  logic [AW-1:0]       commit_mem_dest;
  logic [DW-1:0]       commit_value;
  logic                commit_jump_reg;
  logic [TAG_BITS:0]   count;

  always #5 clk = ~clk;

  rob_commit_buffer #(.DEPTH(DEPTH), .TAG_BITS(TAG_BITS), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_inst_type(alloc_inst_type),
    .alloc_reg_dest(alloc_reg_dest), .alloc_mem_dest(alloc_mem_dest), .alloc_jump_reg(alloc_jump_reg),
    .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_mem_dest(cdb_mem_dest),
    .rd_tag(rd_tag), .rd_ready(rd_ready), .rd_value(rd_value),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .commit_tag(commit_tag),
    .commit_inst_type(commit_inst_type), .commit_reg_dest(commit_reg_dest),
    .commit_mem_dest(commit_mem_dest), .commit_value(commit_value),
    .commit_jump_reg(commit_jump_reg), .count(count)
  );

  // Model: in-flight instructions in program order; the front is the oldest.
  typedef struct {
    int            tag;
    logic [1:0]    typ;
    logic [5:0]    rdst;
    logic [AW-1:0] md;
    logic [DW-1:0] val;
    logic          jr;
    logic          rdy;
  } mentry_t;

  mentry_t mq[$];
  int      m_tail;
  int      n_vec = 0;
  int      n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0; alloc_valid = 1'b0; alloc_inst_type = 2'd0; alloc_reg_dest = 6'd0;
    alloc_mem_dest = '0; alloc_jump_reg = 1'b0; cdb_valid = 1'b0; cdb_tag = '0;
    cdb_value = '0; cdb_mem_dest = '0; rd_tag = '0; commit_ready = 1'b0;
  endtask

  task automatic set_alloc(input logic [1:0] typ, input logic [5:0] rdst, input logic [AW-1:0] md);
    alloc_valid = 1'b1; alloc_inst_type = typ; alloc_reg_dest = rdst; alloc_mem_dest = md;
  endtask

  task automatic set_cdb(input int tag, input logic [DW-1:0] val, input logic [AW-1:0] md);
    cdb_valid = 1'b1; cdb_tag = TAG_BITS'(tag); cdb_value = val; cdb_mem_dest = md;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_alloc_ready"},  64'(alloc_ready), 64'd1);
    check({pfx, "_alloc_tag"},    64'(alloc_tag), 64'd0);
    check({pfx, "_commit_valid"}, 64'(commit_valid), 64'd0);
    check({pfx, "_commit_value"}, 64'(commit_value), 64'd0);
    check({pfx, "_commit_fields"},
          64'({commit_tag, commit_inst_type, commit_reg_dest, commit_mem_dest, commit_jump_reg}), 64'd0);
    check({pfx, "_rd_ready"},     64'(rd_ready), 64'd0);
    check({pfx, "_count"},        64'(count), 64'd0);
  endtask

  // One clock: predict outputs from the model, compare before the edge, then advance the model.
  task automatic cycle();
    bit            a_rdy, e_cv, byp, e_rr;
    mentry_t       h;
    logic [DW-1:0] e_val, e_rv;
    logic [AW-1:0] e_md;
    a_rdy = (mq.size() < int'(DEPTH));
    e_cv = 1'b0; byp = 1'b0; e_rr = 1'b0; e_rv = '0; e_val = '0; e_md = '0;
    if (mq.size() > 0) begin
      h = mq[0]; e_val = h.val; e_md = h.md;
`ifdef ROB_COMMIT_BYPASS_EN
      if (cdb_valid && int'(cdb_tag) == h.tag && !h.rdy) begin
        byp = 1'b1; e_val = cdb_value;
        if (h.typ == 2'd1) e_md = cdb_mem_dest;
      end
`endif
      e_cv = h.rdy || byp;
    end
    foreach (mq[i]) if (mq[i].tag == int'(rd_tag) && mq[i].rdy) begin e_rr = 1'b1; e_rv = mq[i].val; end
    #1;
    check("alloc_ready", 64'(alloc_ready), 64'(a_rdy));
    check("alloc_tag", 64'(alloc_tag), 64'(m_tail));
    check("count", 64'(count), 64'(mq.size()));
    check("commit_valid", 64'(commit_valid), 64'(e_cv));
    if (e_cv) begin
      check("commit_tag", 64'(commit_tag), 64'(h.tag));
      check("commit_inst_type", 64'(commit_inst_type), 64'(h.typ));
      check("commit_reg_dest", 64'(commit_reg_dest), 64'(h.rdst));
      check("commit_mem_dest", 64'(commit_mem_dest), 64'(e_md));
      check("commit_value", 64'(commit_value), 64'(e_val));
      check("commit_jump_reg", 64'(commit_jump_reg), 64'(h.jr));
    end
    check("rd_ready", 64'(rd_ready), 64'(e_rr));
    if (e_rr) check("rd_value", 64'(rd_value), 64'(e_rv));
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_tail = 0;
    end else begin
      if (cdb_valid)
        foreach (mq[i])
          if (mq[i].tag == int'(cdb_tag) && !mq[i].rdy) begin
            mq[i].val = cdb_value; mq[i].rdy = 1'b1;
            if (mq[i].typ == 2'd1) mq[i].md = cdb_mem_dest;
          end
      if (e_cv && commit_ready) void'(mq.pop_front());
      if (alloc_valid && a_rdy) begin
        mq.push_back('{tag: m_tail, typ: alloc_inst_type, rdst: alloc_reg_dest, md: alloc_mem_dest,
                       val: '0, jr: alloc_jump_reg, rdy: (alloc_inst_type == 2'd3)});
        m_tail = (m_tail + 1) % int'(DEPTH);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int t0, t1;
    idle();
    rst = 1'b1; m_tail = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic allocate / complete / commit.
    set_alloc(2'd0, 6'd5, '0); cycle(); idle();
    check("t1_count", 64'(count), 64'd1);
    check("t1_cv_before_cdb", 64'(commit_valid), 64'd0);
    set_cdb(0, 32'hDEADBEEF, '0); cycle(); idle();
    check("t1_cv", 64'(commit_valid), 64'd1);
    check("t1_value", 64'(commit_value), 64'hDEADBEEF);
    check("t1_reg_dest", 64'(commit_reg_dest), 64'd5);
    commit_ready = 1'b1; cycle(); idle();
    check("t1_count_after", 64'(count), 64'd0);

    // Full buffer refuses allocation even while committing.
    set_alloc(2'd3, 6'd1, '0); cycle(); cycle(); idle();
    check("t2_full_ready", 64'(alloc_ready), 64'd0);
    check("t2_full_count", 64'(count), 64'd2);
    set_alloc(2'd3, 6'd2, '0); commit_ready = 1'b1; cycle(); idle();
    check("t2_count_no_alloc", 64'(count), 64'd1);
    set_alloc(2'd3, 6'd3, '0); cycle(); idle();
    check("t2_count_refill", 64'(count), 64'd2);
    commit_ready = 1'b1; cycle(); cycle(); idle();

    // Out-of-order completion still commits in order.
    t0 = m_tail; t1 = (m_tail + 1) % int'(DEPTH);
    set_alloc(2'd0, 6'd10, '0); cycle(); set_alloc(2'd0, 6'd11, '0); cycle(); idle();
    set_cdb(t1, 32'd7, '0); cycle(); idle();
    check("t3_cv_ooo", 64'(commit_valid), 64'd0);
    set_cdb(t0, 32'd3, '0); cycle(); idle();
    check("t3_first", 64'(commit_value), 64'd3);
    commit_ready = 1'b1; cycle(); idle();
    check("t3_second_valid", 64'(commit_valid), 64'd1);
    check("t3_second", 64'(commit_value), 64'd7);
    commit_ready = 1'b1; cycle(); idle();

    // STORE address resolved by the CDB; duplicate completion ignored.
    t0 = m_tail;
    set_alloc(2'd1, 6'd0, '0); cycle(); idle();
    set_cdb(t0, 32'd9, 26'h1234); cycle(); idle();
    set_cdb(t0, 32'd10, 26'h3FF); cycle(); idle();
    check("t4_mem_dest", 64'(commit_mem_dest), 64'h1234);
    check("t4_type", 64'(commit_inst_type), 64'd1);
    check("t4_value", 64'(commit_value), 64'd9);
    commit_ready = 1'b1; cycle(); idle();

    // Flush overrides allocate and completion.
    set_alloc(2'd0, 6'd20, '0); cycle(); cycle(); idle();
    flush = 1'b1; set_alloc(2'd0, 6'd21, '0); set_cdb(0, 32'd1, '0); cycle(); idle();
    check("t5_count", 64'(count), 64'd0);
    check("t5_alloc_tag", 64'(alloc_tag), 64'd0);
    check("t5_cv", 64'(commit_valid), 64'd0);
    check("t5_alloc_ready", 64'(alloc_ready), 64'd1);

    // Asynchronous reset in the middle of a cycle.
    set_alloc(2'd0, 6'd22, 26'h55); alloc_jump_reg = 1'b1; cycle(); idle();
    set_cdb(0, 32'hCAFE, '0); cycle(); idle();
    check("t5_cv_pre_rst", 64'(commit_valid), 64'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async");
    mq.delete(); m_tail = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Completion to the head while the consumer is ready.
    t0 = m_tail;
    set_alloc(2'd0, 6'd30, '0); cycle(); idle();
    set_cdb(t0, 32'd55, '0); commit_ready = 1'b1; cycle(); idle();
`ifdef ROB_COMMIT_BYPASS_EN
    check("t6_bypass_count", 64'(count), 64'd0);
`else
    check("t6_nobypass_cv", 64'(commit_valid), 64'd1);
    check("t6_nobypass_count", 64'(count), 64'd1);
    commit_ready = 1'b1; cycle(); idle();
    check("t6_nobypass_count_after", 64'(count), 64'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      alloc_valid     = ($urandom_range(0, 2) != 0);
      alloc_inst_type = 2'($urandom_range(0, 3));
      alloc_reg_dest  = 6'($urandom);
      alloc_mem_dest  = AW'($urandom);
      alloc_jump_reg  = 1'($urandom);
      cdb_valid       = 1'($urandom);
      cdb_tag         = TAG_BITS'($urandom);
      cdb_value       = DW'($urandom);
      cdb_mem_dest    = AW'($urandom);
      rd_tag          = TAG_BITS'($urandom);
      commit_ready    = ($urandom_range(0, 3) != 0);
      flush           = ($urandom_range(0, 63) == 0);
      cycle();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
